// File: rtl/matrix_storage_writer.sv
// Storage-manager write responder: latches a request, writes 3 metadata words and a row-major element stream into a BRAM slot.
// Optional idle-stream abort is enabled with `define MATRIX_WRITER_TIMEOUT_EN.
module matrix_storage_writer #(
  parameter int BLOCK_SIZE = 1024,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_MATRICES = 8,
  parameter int MAX_DIM = 32,
`ifdef MATRIX_WRITER_TIMEOUT_EN
  parameter int METADATA_WORDS = 3,
  parameter int TIMEOUT_CYCLES = 1024
`else
  parameter int METADATA_WORDS = 3
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  write_ready,
  input  logic                  write_request,
  input  logic [2:0]            matrix_id,
  input  logic [7:0]            actual_rows,
  input  logic [7:0]            actual_cols,
  input  logic [7:0]            matrix_name [0:7],
  output logic                  writer_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  write_done,
  output logic                  write_error,
  output logic                  busy,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_META,
    S_STREAM,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BS = ADDR_WIDTH'(BLOCK_SIZE);
  localparam logic [ADDR_WIDTH-1:0] MW = ADDR_WIDTH'(METADATA_WORDS);

  state_t state, state_n;

  logic                  take;
  logic [2:0]            id_q;
  logic [7:0]            rows_q;
  logic [7:0]            cols_q;
  logic [7:0]            name_q [0:7];
  logic [ADDR_WIDTH-1:0] base_q;
  logic [15:0]           total_q;
  logic [15:0]           cnt_q, cnt_n;
  logic [1:0]            meta_q, meta_n;
  logic                  we_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] din_n;
  logic                  bad;
  logic [DATA_WIDTH-1:0] shape_w;
  logic [DATA_WIDTH-1:0] name_hi;
  logic [DATA_WIDTH-1:0] name_lo;

`ifdef MATRIX_WRITER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [IW-1:0] idle_q, idle_n;
`endif

  assign bad = (32'(id_q) >= NUM_MATRICES)
            || (rows_q == '0)
            || (cols_q == '0)
            || (32'(rows_q) > MAX_DIM)
            || (32'(cols_q) > MAX_DIM)
            || (32'(total_q) > BLOCK_SIZE - METADATA_WORDS);

  // Shape packing matches decode_shape_word: rows in [15:8], cols in [7:0]
  assign shape_w = DATA_WIDTH'({rows_q, cols_q});
  assign name_hi = DATA_WIDTH'({name_q[0], name_q[1], name_q[2], name_q[3]});
  assign name_lo = DATA_WIDTH'({name_q[4], name_q[5], name_q[6], name_q[7]});

  always_comb begin
    state_n = state;
    take    = 1'b0;
    cnt_n   = cnt_q;
    meta_n  = meta_q;
    we_n    = 1'b0;
    addr_n  = bram_addr;
    din_n   = bram_din;
`ifdef MATRIX_WRITER_TIMEOUT_EN
    idle_n  = idle_q;
`endif
    unique case (state)
      S_IDLE: begin
        if (write_ready && write_request) begin
          take    = 1'b1;
          state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        cnt_n = '0;
        if (bad) begin
          state_n = S_ERROR;
        end else begin
          state_n = S_META;
          meta_n  = 2'd1;
          we_n    = 1'b1;
          addr_n  = base_q;
          din_n   = shape_w;
        end
      end
      S_META: begin
        unique case (1'b1)
          meta_q == 2'd1: begin
            we_n   = 1'b1;
            addr_n = base_q + ADDR_WIDTH'(1);
            din_n  = name_hi;
            meta_n = 2'd2;
          end
          meta_q == 2'd2: begin
            we_n   = 1'b1;
            addr_n = base_q + ADDR_WIDTH'(2);
            din_n  = name_lo;
            meta_n = 2'd3;
          end
          default: begin
            state_n = S_STREAM;
`ifdef MATRIX_WRITER_TIMEOUT_EN
            idle_n  = '0;
`endif
          end
        endcase
      end
      S_STREAM: begin
        if (data_valid) begin
          we_n   = 1'b1;
          addr_n = base_q + MW + ADDR_WIDTH'(cnt_q);
          din_n  = data_in;
          cnt_n  = cnt_q + 16'd1;
`ifdef MATRIX_WRITER_TIMEOUT_EN
          idle_n = '0;
`endif
          if (cnt_q == total_q - 16'd1) state_n = S_DONE;
        end
`ifdef MATRIX_WRITER_TIMEOUT_EN
        else if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
          state_n = S_ERROR;
        end else begin
          idle_n = idle_q + IW'(1);
        end
`endif
      end
      S_DONE:  state_n = S_IDLE;
      S_ERROR: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Every output is a register loaded from the next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      write_ready  <= 1'b0;
      writer_ready <= 1'b0;
      write_done   <= 1'b0;
      write_error  <= 1'b0;
      busy         <= 1'b0;
      bram_we      <= 1'b0;
      bram_addr    <= '0;
      bram_din     <= '0;
      cnt_q        <= '0;
      meta_q       <= '0;
    end else begin
      state        <= state_n;
      write_ready  <= (state_n == S_IDLE);
      writer_ready <= (state_n == S_STREAM);
      write_done   <= (state_n == S_DONE) || (state_n == S_ERROR);
      write_error  <= (state_n == S_ERROR);
      busy         <= (state_n != S_IDLE);
      bram_we      <= we_n;
      bram_addr    <= addr_n;
      bram_din     <= din_n;
      cnt_q        <= cnt_n;
      meta_q       <= meta_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q    <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      base_q  <= '0;
      total_q <= '0;
      for (int i = 0; i < 8; i++) name_q[i] <= '0;
    end else if (take) begin
      id_q    <= matrix_id;
      rows_q  <= actual_rows;
      cols_q  <= actual_cols;
      base_q  <= ADDR_WIDTH'(matrix_id) * BS;
      total_q <= 16'(actual_rows) * 16'(actual_cols);
      for (int i = 0; i < 8; i++) name_q[i] <= matrix_name[i];
    end
  end

`ifdef MATRIX_WRITER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_n;
  end
`endif

endmodule

// File: tb/tb_matrix_storage_writer.sv
// Directed bench for matrix_storage_writer: metadata/element layout,
// rejects, surplus beats, mid-stream reset and idle-stream behaviour.
`timescale 1ns/1ps
module tb_matrix_storage_writer;

  localparam int BS = 128;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          write_ready;
  logic          write_request = 1'b0;
  logic [2:0]    matrix_id = '0;
  logic [7:0]    actual_rows = '0;
  logic [7:0]    actual_cols = '0;
  logic [7:0]    name [0:7];
  logic          writer_ready;
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          write_done;
  logic          write_error;
  logic          busy;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int we_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int checks = 0;
  int errors = 0;

  matrix_storage_writer #(
    .BLOCK_SIZE(BS),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
`ifdef MATRIX_WRITER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .write_ready(write_ready),
    .write_request(write_request),
    .matrix_id(matrix_id),
    .actual_rows(actual_rows),
    .actual_cols(actual_cols),
    .matrix_name(name),
    .writer_ready(writer_ready),
    .data_in(data_in),
    .data_valid(data_valid),
    .write_done(write_done),
    .write_error(write_error),
    .busy(busy),
    .bram_we(bram_we),
    .bram_addr(bram_addr),
    .bram_din(bram_din)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #2;
    if (bram_we) begin
      mem[bram_addr] = bram_din;
      we_cnt++;
    end
    if (write_done) done_cnt++;
    if (write_done && write_error) err_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic request(input logic [2:0] id, input logic [7:0] r,
                         input logic [7:0] c, input string nm);
    int n;
    n = 0;
    while (!write_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", write_ready, 1);
    matrix_id = id;
    actual_rows = r;
    actual_cols = c;
    for (int i = 0; i < 8; i++) name[i] = nm[i];
    write_request = 1'b1;
    @(negedge clk);
    write_request = 1'b0;
    matrix_id = 3'd7;
    actual_rows = 8'hFF;
    actual_cols = 8'hFF;
    for (int i = 0; i < 8; i++) name[i] = 8'h7A;
  endtask

  task automatic wait_stream(output int n);
    n = 0;
    while (!writer_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_done(input int lim, output int n);
    n = 0;
    while (!write_done && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic beat(input logic [DW-1:0] v);
    data_valid = 1'b1;
    data_in = v;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    check("rst_write_ready", write_ready, 0);
    check("rst_outputs", {writer_ready, write_done, write_error, busy, bram_we}, 0);
    check("rst_addr_din", {bram_addr, bram_din}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready_first", write_ready, 0);
    @(negedge clk);
    check("rst_ready_after", write_ready, 1);
  endtask

  int n, w0, d0, e0;
  int gaps [9] = '{0, 2, 1, 0, 3, 0, 1, 2, 0};
  logic [7:0] rst_bad [3] = '{8'd0, 8'd33, 8'd32};
  logic [2:0] rst_id  [3] = '{3'd0, 3'd1, 3'd1};

  initial begin
    for (int i = 0; i < 8; i++) name[i] = '0;
    @(negedge clk);
    reset_dut();

    // 8x10 into slot 0
    w0 = we_cnt; d0 = done_cnt; e0 = err_cnt;
    request(3'd0, 8'd8, 8'd10, "CONV_RES");
    check("t1_busy", busy, 1);
    check("t1_ready_low", write_ready, 0);
    wait_stream(n);
    check("t1_latency", n, 4);
    for (int i = 1; i <= 80; i++) beat(DW'(i));
    check("t1_done", write_done, 1);
    check("t1_error", write_error, 0);
    check("t1_wr_low", writer_ready, 0);
    check("t1_shape", mem[0], 32'h0000_080A);
    check("t1_name_hi", mem[1], 32'h434F_4E56);
    check("t1_name_lo", mem[2], 32'h5F52_4553);
    for (int i = 0; i < 80; i++) check("t1_elem", mem[3 + i], DW'(i + 1));
    check("t1_we_count", we_cnt - w0, 83);
    @(negedge clk);
    check("t1_done_pulse", write_done, 0);
    check("t1_done_count", done_cnt - d0, 1);
    check("t1_err_count", err_cnt - e0, 0);

    // 3x3 into slot 2 with a lagging, gappy initiator
    request(3'd2, 8'd3, 8'd3, "GAPPY_3X");
    wait_stream(n);
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      beat(DW'(32'h100 + i));
      if (i < 8) repeat (gaps[i]) @(negedge clk);
    end
    check("t2_done", write_done, 1);
    check("t2_wr_low", writer_ready, 0);
    check("t2_error", write_error, 0);
    check("t2_shape", mem[256], 32'h0000_0303);
    for (int i = 0; i < 9; i++) check("t2_elem", mem[259 + i], DW'(32'h100 + i));
    @(negedge clk);

    // rejected requests
    for (int k = 0; k < 3; k++) begin
      w0 = we_cnt;
      request(rst_id[k], rst_bad[k], k == 2 ? 8'd32 : 8'd4, "BADREQ__");
      check("t3_busy", busy, 1);
      wait_done(10, n);
      check("t3_latency", n, 1);
      check("t3_error", write_error, 1);
      @(negedge clk);
      check("t3_done_pulse", write_done, 0);
      check("t3_no_writes", we_cnt - w0, 0);
    end

    // surplus beats and a request during STREAM
    w0 = we_cnt; d0 = done_cnt; e0 = err_cnt;
    request(3'd3, 8'd3, 8'd3, "ADD_OUT0");
    wait_stream(n);
    for (int i = 0; i < 11; i++) begin
      data_valid = 1'b1;
      data_in = DW'(32'h300 + i);
      if (i == 2) begin
        write_request = 1'b1;
        matrix_id = 3'd5;
        actual_rows = 8'd1;
        actual_cols = 8'd1;
      end
      if (i == 5) write_request = 1'b0;
      if (i == 4) check("t4_ready_busy", write_ready, 0);
      @(negedge clk);
    end
    data_valid = 1'b0;
    @(negedge clk);
    check("t4_we_count", we_cnt - w0, 12);
    check("t4_done_count", done_cnt - d0, 1);
    check("t4_err_count", err_cnt - e0, 0);
    for (int i = 0; i < 9; i++) check("t4_elem", mem[387 + i], DW'(32'h300 + i));
    check("t4_idle", busy, 0);

    // reset mid-stream, then a clean 2x2
    request(3'd4, 8'd3, 8'd3, "RESET_ME");
    wait_stream(n);
    for (int i = 0; i < 4; i++) beat(DW'(32'h400 + i));
    reset_dut();
    d0 = done_cnt;
    request(3'd4, 8'd2, 8'd2, "ABCDEFGH");
    wait_stream(n);
    check("t5_latency", n, 4);
    for (int i = 0; i < 4; i++) beat(DW'(32'h500 + i));
    check("t5_done", write_done, 1);
    check("t5_error", write_error, 0);
    check("t5_shape", mem[512], 32'h0000_0202);
    check("t5_name_hi", mem[513], 32'h4142_4344);
    check("t5_name_lo", mem[514], 32'h4546_4748);
    for (int i = 0; i < 4; i++) check("t5_elem", mem[515 + i], DW'(32'h500 + i));
    @(negedge clk);
    check("t5_done_count", done_cnt - d0, 1);

    // idle stream
    d0 = done_cnt;
    request(3'd6, 8'd3, 8'd3, "IDLE_ONE");
    wait_stream(n);
    for (int i = 0; i < 3; i++) beat(DW'(32'h600 + i));
`ifdef MATRIX_WRITER_TIMEOUT_EN
    wait_done(200, n);
    check("t6_timeout_cycles", n, 16);
    check("t6_done", write_done, 1);
    check("t6_error", write_error, 1);
    for (int i = 0; i < 3; i++) check("t6_kept", mem[771 + i], DW'(32'h600 + i));
`else
    repeat (100) @(negedge clk);
    check("t6_still_stream", writer_ready, 1);
    check("t6_still_busy", busy, 1);
    check("t6_no_done", done_cnt - d0, 0);
`endif
    @(negedge clk);
    reset_dut();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
